// File: rtl/hazard_pkg.sv
// Shared decode constants, instruction field positions and class decoder
// for the ID-stage hazard scoreboard.
package hazard_pkg;

  localparam int unsigned OPC_W  = 5;
  localparam int unsigned RD_LSB = 11;
  localparam int unsigned RS_LSB = 8;
  localparam int unsigned RT_LSB = 5;

  localparam logic [OPC_W-1:0] OP_LOAD    = 5'b10000;
  localparam logic [OPC_W-1:0] OP_STORE   = 5'b10001;
  localparam logic [2:0]       CLS_BRANCH = 3'b101;
  localparam logic [2:0]       CLS_JUMP   = 3'b111;
  localparam logic [2:0]       CLS_MEMRD  = 3'b100;

  typedef struct packed {
    logic load;
    logic store;
    logic branch;
    logic jump;
    logic reads_src;
  } dec_t;

  // Classify an opcode; reads_src covers ALU ops and memory ops that read rs/rt
  function automatic dec_t decode(input logic [OPC_W-1:0] op);
    dec_t d;
    d.load      = (op == OP_LOAD);
    d.store     = (op == OP_STORE);
    d.branch    = (op[4:2] == CLS_BRANCH);
    d.jump      = (op[4:2] == CLS_JUMP);
    d.reads_src = ~op[4] | (op[4:2] == CLS_MEMRD);
    return d;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard interface: instruction/branch status in, pipeline
// control and stall counter out.
interface hazard_scoreboard_if #(
  parameter int unsigned INSTR_W     = 19,
  parameter int unsigned STALL_CNT_W = 16
) ();

  logic [INSTR_W-1:0]     id_instr;
  logic                   id_valid;
  logic                   do_branch;
  logic                   pc_writebar;
  logic                   if_id_loadbar;
  logic                   if_id_flush;
  logic                   id_ex_flush;
  logic [STALL_CNT_W-1:0] stall_cycles;

  modport master (
    output id_instr, id_valid, do_branch,
    input  pc_writebar, if_id_loadbar, if_id_flush, id_ex_flush, stall_cycles
  );

  modport slave (
    input  id_instr, id_valid, do_branch,
    output pc_writebar, if_id_loadbar, if_id_flush, id_ex_flush, stall_cycles
  );

endinterface

// File: rtl/hazard_reg_countdown.sv
// One scoreboard entry: loads LOAD_VAL on set, otherwise counts down to
// zero; busy while nonzero.
module hazard_reg_countdown #(
  parameter int unsigned CNT_W    = 1,
  parameter int unsigned LOAD_VAL = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_set,
  output logic o_busy
);

  logic [CNT_W-1:0] r_cnt;

  // A new load overrides any countdown still in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_set) begin
      r_cnt <= CNT_W'(LOAD_VAL);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: per-register load scoreboard with multi-cycle
// load-use stall, branch/jump front-end flush and saturating stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned INSTR_W        = 19,
  parameter int unsigned REG_ADDR_W     = 3,
  parameter int unsigned LOAD_LATENCY   = 1,
  parameter int unsigned BRANCH_PENALTY = 1,
  parameter int unsigned STALL_CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  hazard_scoreboard_if.slave  bus
);

  localparam int unsigned NREG  = 2 ** REG_ADDR_W;
  localparam int unsigned CNT_W = $clog2(LOAD_LATENCY + 1);
  localparam int unsigned PEN_W = 2;

  logic [OPC_W-1:0]       w_op;
  logic [REG_ADDR_W-1:0]  w_rd;
  logic [REG_ADDR_W-1:0]  w_rs;
  logic [REG_ADDR_W-1:0]  w_rt;
  dec_t                   w_dec;
  logic [NREG-1:0]        w_busy;
  logic                   w_in_pen;
  logic                   w_eff_valid;
  logic                   w_src_busy;
  logic                   w_stall;
  logic                   w_issue;
  logic                   w_load_issue;
  logic                   w_trig;
  logic                   w_unused;

  logic [PEN_W-1:0]       r_pen_cnt;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  assign w_op  = bus.id_instr[INSTR_W-1 -: OPC_W];
  assign w_rd  = bus.id_instr[RD_LSB +: REG_ADDR_W];
  assign w_rs  = bus.id_instr[RS_LSB +: REG_ADDR_W];
  assign w_rt  = bus.id_instr[RT_LSB +: REG_ADDR_W];
  assign w_dec = decode(w_op);

  // Stores are ordinary source readers; their rd (store data) is forwarded in MEM
  assign w_unused = ^{bus.id_instr[RT_LSB-1:0], w_dec.store};

  // Register 0 is hardwired zero and never pending
  assign w_busy[0] = 1'b0;

  for (genvar g = 1; g < NREG; g++) begin : g_reg
    hazard_reg_countdown #(
      .CNT_W    (CNT_W),
      .LOAD_VAL (LOAD_LATENCY)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .i_set  (w_load_issue && (w_rd == REG_ADDR_W'(g))),
      .o_busy (w_busy[g])
    );
  end

  // While the penalty counter runs, ID holds a flushed bubble
  assign w_in_pen     = (r_pen_cnt != '0);
  assign w_eff_valid  = bus.id_valid & ~w_in_pen;
  assign w_src_busy   = ((w_rs != '0) && w_busy[w_rs]) || ((w_rt != '0) && w_busy[w_rt]);
  assign w_stall      = w_eff_valid & w_dec.reads_src & w_src_busy;
  assign w_issue      = w_eff_valid & ~w_stall;
  assign w_load_issue = w_issue & w_dec.load;
  assign w_trig       = w_issue & (w_dec.jump | (w_dec.branch & bus.do_branch));

  // Pipeline control, forced quiet while in reset
  always_comb begin
    bus.pc_writebar   = 1'b0;
    bus.if_id_loadbar = 1'b0;
    bus.id_ex_flush   = 1'b0;
    bus.if_id_flush   = 1'b0;
    if (!rst) begin
      bus.pc_writebar   = w_stall;
      bus.if_id_loadbar = w_stall;
      bus.id_ex_flush   = w_stall;
      bus.if_id_flush   = w_trig | w_in_pen;
    end
  end

  // Penalty countdown covers the flush cycles after the trigger cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pen_cnt <= '0;
    end else if (w_trig) begin
      r_pen_cnt <= PEN_W'(BRANCH_PENALTY - 1);
    end else if (w_in_pen) begin
      r_pen_cnt <= r_pen_cnt - PEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign bus.stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench: three differently parameterised hazard units share one stimulus
// stream and are checked each cycle against a cycle-time reference model.
module tb_hazard_scoreboard;

  localparam logic [4:0] LD  = 5'b10000;
  localparam logic [4:0] ST  = 5'b10001;
  localparam logic [4:0] ADD = 5'b00000;
  localparam logic [4:0] BR  = 5'b10100;
  localparam logic [4:0] JMP = 5'b11100;
  localparam logic [4:0] NOP = 5'b11000;

  logic        clk = 1'b0;
  logic        rst;
  logic [18:0] instr;
  logic        valid;
  logic        dob;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.INSTR_W(19), .STALL_CNT_W(16)) hif0 ();
  hazard_scoreboard_if #(.INSTR_W(19), .STALL_CNT_W(2))  hif1 ();
  hazard_scoreboard_if #(.INSTR_W(19), .STALL_CNT_W(16)) hif2 ();

  assign hif0.id_instr = instr; assign hif0.id_valid = valid; assign hif0.do_branch = dob;
  assign hif1.id_instr = instr; assign hif1.id_valid = valid; assign hif1.do_branch = dob;
  assign hif2.id_instr = instr; assign hif2.id_valid = valid; assign hif2.do_branch = dob;

  hazard_scoreboard #(.INSTR_W(19), .REG_ADDR_W(3), .LOAD_LATENCY(1),
                      .BRANCH_PENALTY(2), .STALL_CNT_W(16))
    dut0 (.clk(clk), .rst(rst), .bus(hif0.slave));
  hazard_scoreboard #(.INSTR_W(19), .REG_ADDR_W(3), .LOAD_LATENCY(3),
                      .BRANCH_PENALTY(1), .STALL_CNT_W(2))
    dut1 (.clk(clk), .rst(rst), .bus(hif1.slave));
  hazard_scoreboard #(.INSTR_W(19), .REG_ADDR_W(3), .LOAD_LATENCY(7),
                      .BRANCH_PENALTY(3), .STALL_CNT_W(16))
    dut2 (.clk(clk), .rst(rst), .bus(hif2.slave));

  // {pc_writebar, if_id_loadbar, if_id_flush, id_ex_flush}
  logic [3:0]  o_ctl [3];
  logic [31:0] o_cnt [3];
  assign o_ctl[0] = {hif0.pc_writebar, hif0.if_id_loadbar, hif0.if_id_flush, hif0.id_ex_flush};
  assign o_ctl[1] = {hif1.pc_writebar, hif1.if_id_loadbar, hif1.if_id_flush, hif1.id_ex_flush};
  assign o_ctl[2] = {hif2.pc_writebar, hif2.if_id_loadbar, hif2.if_id_flush, hif2.id_ex_flush};
  assign o_cnt[0] = 32'(hif0.stall_cycles);
  assign o_cnt[1] = 32'(hif1.stall_cycles);
  assign o_cnt[2] = 32'(hif2.stall_cycles);

  int ll   [3] = '{1, 3, 7};
  int bp   [3] = '{2, 1, 3};
  int smax [3] = '{65535, 3, 65535};

  // Model: cycle at which each register becomes readable, last flush cycle
  int rdy [3][8];
  int fe  [3] = '{-1, -1, -1};
  int mcnt[3] = '{0, 0, 0};
  int now = 0;

  int tests = 0;
  int fails = 0;
  int wst [3];
  int wfl [3];

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic logic [18:0] mk(input logic [4:0] op, input int rd, input int rs, input int rt);
    return {op, 3'(rd), 3'(rs), 3'(rt), 5'b0};
  endfunction

  task automatic step(input logic [18:0] ins, input logic v, input logic b, input logic r);
    logic [4:0] op;
    int rd, rs, rt;
    logic in_pen, eff, ld, rsrc, br, jp, hz, st, iss, tg;
    logic [3:0] exp_ctl;
    instr = ins; valid = v; dob = b; rst = r;
    op = ins[18:14];
    rd = int'(ins[13:11]); rs = int'(ins[10:8]); rt = int'(ins[7:5]);
    ld   = (op == LD);
    rsrc = (op[4] == 1'b0) || (op[4:2] == 3'b100);
    br   = (op[4:2] == 3'b101);
    jp   = (op[4:2] == 3'b111);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      in_pen = (now <= fe[k]);
      eff = v && !in_pen;
      hz  = (rs != 0 && now < rdy[k][rs]) || (rt != 0 && now < rdy[k][rt]);
      st  = eff && rsrc && hz;
      iss = eff && !st;
      tg  = iss && (jp || (br && b));
      exp_ctl = r ? 4'b0000 : {st, st, tg || in_pen, st};
      chk("ctl", k, 32'(o_ctl[k]), 32'(exp_ctl));
      chk("stall_cycles", k, o_cnt[k], 32'(mcnt[k]));
      wst[k] += int'(o_ctl[k][3]);
      wfl[k] += int'(o_ctl[k][1]);
      if (r) begin
        for (int j = 0; j < 8; j++) rdy[k][j] = 0;
        fe[k] = -1;
        mcnt[k] = 0;
      end else begin
        if (st && mcnt[k] < smax[k]) mcnt[k]++;
        if (iss && ld && rd != 0) rdy[k][rd] = now + ll[k] + 1;
        if (tg) fe[k] = now + bp[k] - 1;
      end
    end
    now++;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    for (int k = 0; k < 3; k++) begin wst[k] = 0; wfl[k] = 0; end
  endtask

  task automatic do_reset;
    step(mk(JMP, 0, 0, 0), 1'b1, 1'b1, 1'b1);
    clr();
  endtask

  task automatic win(input string tag, input logic fl, input int e0, input int e1, input int e2);
    chk(tag, 0, 32'(fl ? wfl[0] : wst[0]), 32'(e0));
    chk(tag, 1, 32'(fl ? wfl[1] : wst[1]), 32'(e1));
    chk(tag, 2, 32'(fl ? wfl[2] : wst[2]), 32'(e2));
  endtask

  initial begin
    logic [4:0] ops [6];
    logic [4:0] op;
    int pick;
    ops = '{LD, ST, ADD, BR, JMP, NOP};
    for (int k = 0; k < 3; k++) for (int j = 0; j < 8; j++) rdy[k][j] = 0;
    clr();
    do_reset();
    do_reset();

    // Load-use immediately behind a load: LOAD_LATENCY stalls
    step(mk(LD, 3, 1, 0), 1'b1, 1'b0, 1'b0);
    repeat (9) step(mk(ADD, 1, 3, 2), 1'b1, 1'b0, 1'b0);
    win("t1_stalls", 1'b0, 1, 3, 7);
    win("t1_count", 1'b0, int'(o_cnt[0]), int'(o_cnt[1]), int'(o_cnt[2]));
    chk("t1_cnt_val", 0, o_cnt[0], 32'd1);

    // One-instruction gap, then load to r0
    do_reset();
    step(mk(LD, 5, 1, 0), 1'b1, 1'b0, 1'b0);
    step(mk(NOP, 0, 0, 0), 1'b1, 1'b0, 1'b0);
    repeat (9) step(mk(ADD, 1, 2, 5), 1'b1, 1'b0, 1'b0);
    win("t2_gap", 1'b0, 0, 2, 6);
    do_reset();
    step(mk(LD, 0, 1, 0), 1'b1, 1'b0, 1'b0);
    repeat (3) step(mk(ADD, 1, 0, 0), 1'b1, 1'b0, 1'b0);
    win("t2_r0", 1'b0, 0, 0, 0);

    // Store data register match alone never stalls; a base register match does
    do_reset();
    step(mk(LD, 4, 1, 0), 1'b1, 1'b0, 1'b0);
    repeat (3) step(mk(ST, 4, 1, 2), 1'b1, 1'b0, 1'b0);
    win("t3_st_rd", 1'b0, 0, 0, 0);
    do_reset();
    step(mk(LD, 4, 1, 0), 1'b1, 1'b0, 1'b0);
    repeat (9) step(mk(ST, 2, 4, 1), 1'b1, 1'b0, 1'b0);
    win("t3_st_rs", 1'b0, 1, 3, 7);

    // Branch/jump penalty lengths
    do_reset();
    step(mk(BR, 0, 1, 2), 1'b1, 1'b1, 1'b0);
    repeat (5) step(mk(ADD, 1, 2, 3), 1'b1, 1'b0, 1'b0);
    win("t4_taken", 1'b1, 2, 1, 3);
    clr();
    step(mk(BR, 0, 1, 2), 1'b1, 1'b0, 1'b0);
    repeat (5) step(mk(ADD, 1, 2, 3), 1'b1, 1'b1, 1'b0);
    win("t4_untaken", 1'b1, 0, 0, 0);
    clr();
    step(mk(JMP, 0, 0, 0), 1'b1, 1'b0, 1'b0);
    repeat (5) step(mk(ADD, 1, 2, 3), 1'b1, 1'b0, 1'b0);
    win("t4_jump", 1'b1, 2, 1, 3);
    do_reset();
    step(mk(JMP, 0, 0, 0), 1'b1, 1'b0, 1'b0);
    step(mk(LD, 6, 1, 0), 1'b1, 1'b0, 1'b0);
    repeat (9) step(mk(ADD, 1, 6, 0), 1'b1, 1'b0, 1'b0);
    win("t4_flushed_load", 1'b0, 0, 3, 0);

    // Reset inside a stall window abandons it
    do_reset();
    step(mk(LD, 2, 1, 0), 1'b1, 1'b0, 1'b0);
    repeat (2) step(mk(ADD, 1, 2, 0), 1'b1, 1'b0, 1'b0);
    step(mk(ADD, 1, 2, 0), 1'b1, 1'b0, 1'b1);
    clr();
    repeat (3) step(mk(ADD, 1, 2, 0), 1'b1, 1'b0, 1'b0);
    win("t5_after_rst", 1'b0, 0, 0, 0);
    chk("t5_cnt", 0, o_cnt[0], 32'd0);
    chk("t5_cnt", 1, o_cnt[1], 32'd0);
    chk("t5_cnt", 2, o_cnt[2], 32'd0);

    // Saturating counter on the narrow instance
    do_reset();
    step(mk(LD, 5, 1, 0), 1'b1, 1'b0, 1'b0);
    repeat (5) step(mk(ADD, 1, 5, 0), 1'b1, 1'b0, 1'b0);
    step(mk(LD, 5, 1, 0), 1'b1, 1'b0, 1'b0);
    repeat (5) step(mk(ADD, 1, 5, 0), 1'b1, 1'b0, 1'b0);
    win("t6_stalls", 1'b0, 2, 6, 10);
    repeat (3) step(mk(NOP, 0, 0, 0), 1'b1, 1'b0, 1'b0);
    chk("t6_sat", 1, o_cnt[1], 32'd3);
    chk("t6_cnt", 2, o_cnt[2], 32'd10);

    // Random traffic against the model
    do_reset();
    repeat (600) begin
      pick = $urandom_range(0, 6);
      if (pick == 6) op = 5'($urandom);
      else op = ops[pick];
      step(mk(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)),
           ($urandom % 5) != 0, 1'($urandom), ($urandom % 60) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised hazard unit for the 19-bit pipelined MIPS core, placed beside the ID stage.
- Replaces the fixed one-bubble load-use check with a per-register scoreboard of load countdowns, so memories with LOAD_LATENCY wait states are supported.
- Generates a multi-cycle front-end flush for taken branches and jumps, with BRANCH_PENALTY configurable.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- INSTR_W, 19, instruction width; opcode [INSTR_W-1:INSTR_W-5], rd [13:11], rs [10:8], rt [7:5].
- REG_ADDR_W, 3, register address width; register 0 is hardwired zero.
- LOAD_LATENCY, 1, cycles a dependent instruction must wait after a load leaves ID. Legal range is 1..7.
- BRANCH_PENALTY, 1, cycles IF/ID is flushed after a taken branch or jump. Legal range is 1..3.
- STALL_CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- id_instr  in  INSTR_W  instruction currently in ID.
- id_valid  in  1  id_instr is a real instruction, not a bubble.
- do_branch  in  1  branch condition in ID evaluates taken.
- pc_writebar  out  1  hold PC.
- if_id_loadbar  out  1  hold IF/ID register.
- if_id_flush  out  1  clear IF/ID register.
- id_ex_flush  out  1  insert bubble into ID/EX.
- stall_cycles  out  STALL_CNT_W  saturating count of stall cycles.

Behaviour:
- Decode classes:
  - load: opcode 5'b10000.
  - store: opcode 5'b10001.
  - branch: opcode[4:2]=3'b101.
  - jump: opcode[4:2]=3'b111.
  - reads-sources: opcode[4]=0 or opcode[4:2]=3'b100. These read rs and rt.
- Effective valid: eff_valid = id_valid & (pen_cnt==0). While the penalty counter runs, ID holds a flushed bubble.
- Scoreboard: one counter per register, pend[r], each clog2(LOAD_LATENCY+1) bits.
- Stall condition: eff_valid & reads-sources & (pend[rs]!=0 with rs!=0, or pend[rt]!=0 with rt!=0).
- Store exception: if the ID instruction is a store and its rd equals the pending load's target, the rd-field match alone never stalls. Store data is forwarded in MEM.
- On stall, combinationally assert pc_writebar=1, if_id_loadbar=1 and id_ex_flush=1, all in the same cycle.
- Issue is defined as eff_valid & ~stall.
- Scoreboard update at each clock edge:
  - Every nonzero pend[r] decrements by 1.
  - If the issuing instruction is a load with rd!=0, pend[rd] is set to LOAD_LATENCY. Set wins over decrement on the same register.
  - pend[0] is never written.
- Load-use timing: a dependent instruction immediately behind a load stalls exactly LOAD_LATENCY cycles. With LOAD_LATENCY=1 this is the classic single bubble.
- Flush on taken branch or jump:
  - Trigger is an issuing jump, or an issuing branch with do_branch=1.
  - if_id_flush=1 combinationally in that cycle.
  - pen_cnt loads BRANCH_PENALTY-1 and keeps if_id_flush=1 while nonzero, decrementing each cycle.
  - Total flush cycles = BRANCH_PENALTY.
- Priority: flush over stall. A bubble (eff_valid=0) never stalls, never sets the scoreboard, never triggers a flush. Branch and jump never stall by encoding; the priority still holds if they did.
- stall_cycles increments on each cycle with a stall and saturates at all-ones. It never wraps.
- Reset: while rst=1, all pend, pen_cnt and stall_cycles are cleared next edge and all four control outputs are forced 0 in that cycle. Reset mid-stall or mid-penalty abandons it; the first cycle after reset has no hazards pending.
- Latency: control outputs are combinational from inputs and registered state. There is no extra pipeline delay.

Decomposition:
- Shared package hazard_pkg holds:
  - opcode constants (OP_LOAD, OP_STORE, CLS_BRANCH, CLS_JUMP, CLS_MEMRD);
  - field-position localparams for rd, rs and rt;
  - a decode function returning class flags.
- One sub-module: hazard_reg_countdown, a single scoreboard counter with set, decrement and busy. It is instantiated 2**REG_ADDR_W - 1 times via generate.

Test Plan:
1. Latency 1: LOAD_LATENCY=1; issue load r3, then "add r1,r3,r2" -> exactly 1 cycle with pc_writebar=if_id_loadbar=id_ex_flush=1, then issue; stall_cycles=1.
2. Latency 3: LOAD_LATENCY=3; load r5, then instruction reading rt=r5 -> 3 stall cycles. Repeat with a one-instruction gap -> 2 stall cycles. Load to r0 followed by a reader of r0 -> 0 stalls.
3. Store after load: load r4, then store with rd=r4 and independent rs -> no stall. Store with rs=r4 -> 1 stall (LOAD_LATENCY=1).
4. Branch and jump penalty: BRANCH_PENALTY=2; taken branch -> if_id_flush high 2 consecutive cycles. Untaken branch -> 0 cycles. Jump -> 2 cycles. A load in the flushed slot does not set the scoreboard.
5. Reset mid-operation: LOAD_LATENCY=3; load r2, assert rst one cycle in the stall window -> outputs 0 during rst. After rst the dependent reader issues with no stall; stall_cycles=0.
6. Saturation: STALL_CNT_W=2; force 5 stall cycles -> stall_cycles reads 3 and holds.
